bin2bcd_seq: RTL and testbench

Sequential signed-binary to BCD converter feeding the seven-segment digit decoders. It takes a two's-complement result from the processor datapath and computes magnitude and sign. It converts the magnitude to DIGITS packed BCD nibbles using iterative shift-add-3 (double dabble), one bit per clock. Its registered outputs drive the per-digit decoder `bcd` inputs and the sign-segment `neg` input directly, and stay stable between conversions.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 96 +++++++++
 tb/tb_bin2bcd_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter: FSM encoding, digit
// correction constants and an elaboration helper for digit-count checks.
package bcd_pkg;

   localparam int NIB_W = 4;

   localparam logic [NIB_W-1:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [NIB_W-1:0] BCD_ADJ_ADD    = 4'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // True when d decimal digits can hold every w-bit unsigned magnitude.
   function automatic bit digits_ok(input int w, input int d);
      longint p;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p > (longint'(1) << w);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [NIB_W-1:0] in,
   output logic [NIB_W-1:0] out
);

   assign out = (in >= BCD_ADJ_THRESH) ? in + BCD_ADJ_ADD : in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential signed binary to packed BCD converter, one magnitude bit per clock.
// Results and sign are held in output registers that only move on the DONE edge.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter bit SIGNED = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [WIDTH-1:0]        value,
   output logic                    busy,
   output logic                    done,
   output logic [NIB_W*DIGITS-1:0] bcd,
   output logic                    neg
);

   localparam int BW = NIB_W * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   generate
      if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
         $error("bin2bcd_seq: DIGITS too small for WIDTH");
      end
   endgenerate

   state_t             state;
   logic [WIDTH-1:0]   mag;
   logic [BW-1:0]      scratch;
   logic [BW-1:0]      adj;
   logic [CW-1:0]      cnt;
   logic               sign;

   logic               sign_in;
   logic [WIDTH-1:0]   mag_in;
   logic [BW+WIDTH-1:0] shifted;

   // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
   assign sign_in = SIGNED ? value[WIDTH-1] : 1'b0;
   assign mag_in  = sign_in ? -value : value;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .in  (scratch[g*NIB_W +: NIB_W]),
            .out (adj[g*NIB_W +: NIB_W])
         );
      end
   endgenerate

   assign shifted = {adj, mag} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mag     <= '0;
         scratch <= '0;
         cnt     <= '0;
         sign    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
         neg     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sign    <= sign_in;
                  mag     <= mag_in;
                  scratch <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               {scratch, mag} <= shifted;
               cnt            <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= DONE;
            end
            DONE: begin
               bcd   <= scratch;
               neg   <= sign;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a signed and an unsigned instance share the
// stimulus; expected digits are hand-computed decimal values.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  value = '0;

   logic        busy_s, done_s, neg_s;
   logic [11:0] bcd_s;
   logic        busy_u, done_u, neg_u;
   logic [11:0] bcd_u;

   int tests = 0;
   int fails = 0;
   int lat, bc, seen;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .value(value),
      .busy(busy_s), .done(done_s), .bcd(bcd_s), .neg(neg_s)
   );

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .start(start), .value(value),
      .busy(busy_u), .done(done_u), .bcd(bcd_u), .neg(neg_u)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called 1 time unit after an edge; counts edges until done and busy samples.
   task automatic wait_done(output int l, output int b);
      l = -1;
      b = busy_s ? 1 : 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done_s) begin
            l = i;
            break;
         end
         if (busy_s) b++;
      end
   endtask

   task automatic conv(input logic [7:0] v, output int l, output int b);
      start = 1'b1;
      value = v;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(l, b);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy_s, 0);
      chk("rst_done", done_s, 0);
      chk("rst_bcd",  bcd_s,  12'h000);
      chk("rst_neg",  neg_s,  0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      conv(8'd0, lat, bc);
      chk("zero_lat", lat, 9);
      chk("zero_bcd", bcd_s, 12'h000);
      chk("zero_neg", neg_s, 0);

      conv(8'd127, lat, bc);
      chk("p127_lat",  lat, 9);
      chk("p127_busy", bc, 9);
      chk("p127_bcd",  bcd_s, 12'h127);
      chk("p127_neg",  neg_s, 0);
      chk("p127_busy_at_done", busy_s, 0);
      @(posedge clk); #1;
      chk("p127_done_fall", done_s, 0);

      conv(8'h80, lat, bc);
      chk("m128_bcd",  bcd_s, 12'h128);
      chk("m128_neg",  neg_s, 1);
      chk("u128_bcd",  bcd_u, 12'h128);
      chk("u128_neg",  neg_u, 0);

      conv(8'hFF, lat, bc);
      chk("m1_bcd",   bcd_s, 12'h001);
      chk("m1_neg",   neg_s, 1);
      chk("u255_bcd", bcd_u, 12'h255);
      chk("u255_neg", neg_u, 0);
      @(posedge clk); #1;

      // 45, with a stray start pulse of 99 while busy that must be dropped
      start = 1'b1;
      value = 8'd45;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      value = 8'd99;
      @(posedge clk); #1;
      start = 1'b0;
      value = 8'd0;
      chk("hold_bcd_mid", bcd_s, 12'h001);
      wait_done(lat, bc);
      chk("ign_lat", lat, 6);
      chk("ign_bcd", bcd_s, 12'h045);
      chk("ign_neg", neg_s, 0);

      // back-to-back: start accepted during the done cycle
      conv(8'd99, lat, bc);
      chk("b2b_lat", lat, 9);
      chk("b2b_bcd", bcd_s, 12'h099);

      @(posedge clk); #1;
      start = 1'b1;
      value = 8'd200;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("arst_bcd",  bcd_u, 12'h000);
      chk("arst_neg",  neg_u, 0);
      chk("arst_busy", busy_u, 0);
      chk("arst_done", done_u, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done_u || busy_u) seen++;
      end
      chk("arst_no_done", seen, 0);

      conv(8'd7, lat, bc);
      chk("p7_lat", lat, 9);
      chk("p7_bcd", bcd_u, 12'h007);
      chk("p7_bcd_s", bcd_s, 12'h007);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
